// File: rtl/ram64_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : ram64_arbiter_if
// Purpose   : Bundles both requester handshakes and the RAM port of
//             ram64_arbiter. Port-style suffixes are kept on the members so
//             that they read from the arbiter's point of view.
// Members   : req0_i/req1_i, we0_i/we1_i     - request, 1 = write / 0 = read
//             addr0_i/addr1_i [5:0]          - word address
//             wdata0_i/wdata1_i [15:0]       - write data
//             gnt0_o/gnt1_o                  - one-cycle grant pulse
//             rvalid0_o/rvalid1_o            - one-cycle completion pulse
//             rdata0_o/rdata1_o [15:0]       - read data, held until next read
//             ram_address_o [5:0], ram_in_o [15:0], ram_load_o - RAM drive
//             ram_out_i [15:0]               - RAM read data (combinational)
// Modports  : slave  - the arbiter
//             master - the environment (requesters plus the RAM)
// Revision  : 1.0 - initial release
// ============================================================================
interface ram64_arbiter_if;
  logic        req0_i;
  logic        req1_i;
  logic        we0_i;
  logic        we1_i;
  logic [5:0]  addr0_i;
  logic [5:0]  addr1_i;
  logic [15:0] wdata0_i;
  logic [15:0] wdata1_i;
  logic        gnt0_o;
  logic        gnt1_o;
  logic        rvalid0_o;
  logic        rvalid1_o;
  logic [15:0] rdata0_o;
  logic [15:0] rdata1_o;
  logic [5:0]  ram_address_o;
  logic [15:0] ram_in_o;
  logic        ram_load_o;
  logic [15:0] ram_out_i;

  modport slave (
    input  req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i,
    input  wdata0_i, wdata1_i, ram_out_i,
    output gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rdata0_o, rdata1_o,
    output ram_address_o, ram_in_o, ram_load_o
  );

  modport master (
    output req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i,
    output wdata0_i, wdata1_i, ram_out_i,
    input  gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rdata0_o, rdata1_o,
    input  ram_address_o, ram_in_o, ram_load_o
  );
endinterface
`default_nettype wire

// File: rtl/ram64_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram64_arbiter
// Purpose  : Two-requester round-robin arbiter in front of a 64 x 16 RAM with
//            a combinational read port. One transaction is in flight at a
//            time: IDLE/RESP arbitrate, ACCESS drives the RAM for one cycle,
//            RESP reports completion. Back-to-back throughput is one
//            transaction every two cycles (RESP -> ACCESS).
// Ports    : clk_i - clock, all state updates on the rising edge
//            rst_i - asynchronous active-low reset
//            bus   - ram64_arbiter_if.slave: requester 0/1 handshakes and the
//                    RAM port (address, write data, write enable, read data)
// Revision : 1.0 - initial release
// ============================================================================
module ram64_arbiter (
  input  logic           clk_i,
  input  logic           rst_i,
  ram64_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q;
  logic        last_grant_q;   // id of the requester granted most recently
  logic        win_q;          // id of the requester owning the transaction
  logic        we_q;
  logic [5:0]  addr_q;         // doubles as ram_address_o, holds outside ACCESS
  logic [15:0] wdata_q;        // doubles as ram_in_o, holds outside ACCESS
  logic        load_q;
  logic        gnt0_q;
  logic        gnt1_q;
  logic        rvalid0_q;
  logic        rvalid1_q;
  logic [15:0] rdata0_q;
  logic [15:0] rdata1_q;

  logic        any_req;
  logic        win_d;
  logic        we_d;
  logic [5:0]  addr_d;
  logic [15:0] wdata_d;

  assign any_req = bus.req0_i | bus.req1_i;

  // Winner selection: a lone requester wins; on a tie the requester that was
  // not granted last wins. With no request the result is unused.
  always_comb begin
    win_d = bus.req1_i;
    if (bus.req0_i && bus.req1_i) begin
      win_d = ~last_grant_q;
    end
    we_d    = win_d ? bus.we1_i    : bus.we0_i;
    addr_d  = win_d ? bus.addr1_i  : bus.addr0_i;
    wdata_d = win_d ? bus.wdata1_i : bus.wdata0_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      win_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 6'd0;
      wdata_q      <= 16'd0;
      load_q       <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= 16'd0;
      rdata1_q     <= 16'd0;
    end else begin
      // Grant, completion and write-enable are single-cycle pulses.
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      load_q    <= 1'b0;

      case (state_q)
        IDLE, RESP: begin
          if (any_req) begin
            // Payload is latched here so later requester changes are ignored.
            win_q        <= win_d;
            last_grant_q <= win_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            load_q       <= we_d;
            gnt0_q       <= ~win_d;
            gnt1_q       <= win_d;
            state_q      <= ACCESS;
          end else begin
            state_q <= IDLE;
          end
        end

        ACCESS: begin
          // RAM read data is combinational on addr_q, valid by this edge.
          if (!we_q) begin
            if (win_q) begin
              rdata1_q <= bus.ram_out_i;
            end else begin
              rdata0_q <= bus.ram_out_i;
            end
          end
          rvalid0_q <= ~win_q;
          rvalid1_q <= win_q;
          state_q   <= RESP;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0_o        = gnt0_q;
  assign bus.gnt1_o        = gnt1_q;
  assign bus.rvalid0_o     = rvalid0_q;
  assign bus.rvalid1_o     = rvalid1_q;
  assign bus.rdata0_o      = rdata0_q;
  assign bus.rdata1_o      = rdata1_q;
  assign bus.ram_address_o = addr_q;
  assign bus.ram_in_o      = wdata_q;
  assign bus.ram_load_o    = load_q;

endmodule
`default_nettype wire

// File: tb/tb_ram64_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram64_arbiter
// Purpose  : Self-checking bench for ram64_arbiter. A 64 x 16 RAM model sits
//            on the RAM port; two requester agents follow the handshake. A
//            transaction-level reference model predicts, per cycle, the
//            grant/completion pulses, RAM drive and read data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram64_arbiter;

  localparam int CLK_HALF = 5;

  typedef struct packed {
    logic        gnt0;
    logic        gnt1;
    logic        rv0;
    logic        rv1;
    logic        load;
    logic [5:0]  addr;
    logic [15:0] din;
    logic [15:0] rd0;
    logic [15:0] rd1;
  } out_t;

  typedef struct {
    bit          v;
    bit          who;
    bit          we;
    logic [5:0]  addr;
    logic [15:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst_i;
  always #CLK_HALF clk = ~clk;

  ram64_arbiter_if bus ();

  ram64_arbiter dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // RAM on the arbiter's RAM port
  logic [15:0] mem      [64];
  logic [15:0] init_val [64];
  logic        mem_init;

  assign bus.ram_out_i = mem[bus.ram_address_o];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val[i];
    end else if (bus.ram_load_o) begin
      mem[bus.ram_address_o] <= bus.ram_in_o;
    end
  end

  // Reference model state
  logic [15:0] model_mem [64];
  txn_t        q0[$];
  txn_t        q1[$];
  txn_t        cur [2];
  txn_t        slot_acc [4];
  txn_t        slot_rsp [4];
  bit          pend [2];
  bit          last_id;
  bit          arb_ok;
  bit          rand_mode;
  int          comp [2];
  int          cyc;
  out_t        want;
  out_t        got;
  int          checks;
  int          passes;

  function automatic out_t sample();
    out_t o;
    o.gnt0 = bus.gnt0_o;
    o.gnt1 = bus.gnt1_o;
    o.rv0  = bus.rvalid0_o;
    o.rv1  = bus.rvalid1_o;
    o.load = bus.ram_load_o;
    o.addr = bus.ram_address_o;
    o.din  = bus.ram_in_o;
    o.rd0  = bus.rdata0_o;
    o.rd1  = bus.rdata1_o;
    return o;
  endfunction

  function automatic txn_t mk(bit we, logic [5:0] addr, logic [15:0] wdata);
    txn_t t;
    t.v = 1'b1; t.who = 1'b0; t.we = we; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    return mk(1'($urandom_range(1)), 6'($urandom_range(63)), 16'($urandom));
  endfunction

  task automatic issue(int x, txn_t t);
    t.who  = x[0];
    cur[x] = t;
    pend[x] = 1'b1;
    if (x == 0) begin
      bus.req0_i = 1'b1; bus.we0_i = t.we; bus.addr0_i = t.addr; bus.wdata0_i = t.wdata;
    end else begin
      bus.req1_i = 1'b1; bus.we1_i = t.we; bus.addr1_i = t.addr; bus.wdata1_i = t.wdata;
    end
  endtask

  task automatic reset_model();
    q0.delete();
    q1.delete();
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    bus.req0_i = 1'b0;
    bus.req1_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      slot_acc[i].v = 1'b0;
      slot_rsp[i].v = 1'b0;
    end
    want    = '0;
    last_id = 1'b1;
    arb_ok  = 1'b1;
  endtask

  // One clock cycle, entered and left at a falling edge. Raises pending
  // requests, predicts what the coming rising edge decides, then samples the
  // DUT and lets a requester drop its request once it sees its grant.
  task automatic tick();
    txn_t t;
    txn_t w;
    if (rand_mode && !pend[0] && q0.size() == 0 && $urandom_range(3) != 0) q0.push_back(rand_txn());
    if (rand_mode && !pend[1] && q1.size() == 0 && $urandom_range(3) != 0) q1.push_back(rand_txn());
    if (!pend[0] && q0.size() > 0) issue(0, q0.pop_front());
    if (!pend[1] && q1.size() > 0) issue(1, q1.pop_front());

    // The arbiter is busy for exactly one edge after each grant decision.
    if (rst_i && arb_ok && (pend[0] || pend[1])) begin
      if (pend[0] && pend[1]) w = cur[!last_id];
      else if (pend[1])       w = cur[1];
      else                    w = cur[0];
      last_id = w.who;
      slot_acc[(cyc + 1) % 4] = w;
      slot_rsp[(cyc + 2) % 4] = w;
      arb_ok = 1'b0;
    end else begin
      arb_ok = 1'b1;
    end

    @(posedge clk);
    @(negedge clk);
    cyc++;

    want.gnt0 = 1'b0; want.gnt1 = 1'b0;
    want.rv0  = 1'b0; want.rv1  = 1'b0;
    want.load = 1'b0;
    t = slot_acc[cyc % 4];
    if (t.v) begin
      if (t.who) want.gnt1 = 1'b1; else want.gnt0 = 1'b1;
      want.load = t.we;
      want.addr = t.addr;
      want.din  = t.wdata;
    end
    slot_acc[cyc % 4].v = 1'b0;
    t = slot_rsp[cyc % 4];
    if (t.v) begin
      if (t.who) want.rv1 = 1'b1; else want.rv0 = 1'b1;
      if (t.we)       model_mem[t.addr] = t.wdata;
      else if (t.who) want.rd1 = model_mem[t.addr];
      else            want.rd0 = model_mem[t.addr];
    end
    slot_rsp[cyc % 4].v = 1'b0;

    got = sample();
    if (got.gnt0) begin bus.req0_i = 1'b0; pend[0] = 1'b0; end
    if (got.gnt1) begin bus.req1_i = 1'b0; pend[1] = 1'b0; end
    if (got.rv0) comp[0]++;
    if (got.rv1) comp[1]++;
  endtask

  // Reset pulse asserted mid-cycle, away from any clock edge.
  task automatic async_reset(output out_t o);
    #2 rst_i = 1'b0;
    #1 o = sample();
    reset_model();
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    reset_model();
    @(negedge clk);
    got = sample();
    checks++;
    if (got !== want) $display("FAIL reset_values got=%h want=%h", got, want);
    else passes++;
    mem_init = 1'b0;
    rst_i = 1'b1;
  endtask

  task automatic test_write_read();
    int b0 = comp[0];
    q0.push_back(mk(1'b1, 6'd3, 16'hEFFF));
    q0.push_back(mk(1'b0, 6'd3, 16'($urandom)));
    for (int i = 0; i < 20 && comp[0] < b0 + 2; i++) begin
      tick();
      checks++;
      if (got !== want) $display("FAIL wr_rd cyc=%0d got=%h want=%h", cyc, got, want);
      else passes++;
    end
    checks++;
    if (comp[0] != b0 + 2 || got.rd0 !== 16'hEFFF)
      $display("FAIL wr_rd_data completions=%0d rdata0=%h want 2 and efff", comp[0] - b0, got.rd0);
    else passes++;
  endtask

  task automatic test_tie();
    int b0, b1;
    int g0 = -1;
    int g1 = -1;
    async_reset(got);
    checks++;
    if (got !== want) $display("FAIL tie_reset got=%h want=%h", got, want);
    else passes++;
    b0 = comp[0];
    b1 = comp[1];
    q0.push_back(mk(1'b0, 6'd2, 16'($urandom)));
    q1.push_back(mk(1'b0, 6'd63, 16'($urandom)));
    for (int i = 0; i < 20 && (comp[0] < b0 + 1 || comp[1] < b1 + 1); i++) begin
      tick();
      if (got.gnt0 && g0 < 0) g0 = cyc;
      if (got.gnt1 && g1 < 0) g1 = cyc;
      checks++;
      if (got !== want) $display("FAIL tie cyc=%0d got=%h want=%h", cyc, got, want);
      else passes++;
    end
    checks++;
    if (g0 < 0 || g1 != g0 + 2)
      $display("FAIL tie_order gnt0_cyc=%0d gnt1_cyc=%0d want gnt1 two cycles after gnt0", g0, g1);
    else passes++;
  endtask

  task automatic test_contention();
    int b0, b1;
    int nseen = 0;
    int prev  = 0;
    async_reset(got);
    checks++;
    if (got !== want) $display("FAIL contend_reset got=%h want=%h", got, want);
    else passes++;
    b0 = comp[0];
    b1 = comp[1];
    for (int i = 0; i < 4; i++) begin
      q0.push_back(rand_txn());
      q1.push_back(rand_txn());
    end
    for (int i = 0; i < 40 && (comp[0] < b0 + 4 || comp[1] < b1 + 4); i++) begin
      tick();
      checks++;
      if (got !== want) $display("FAIL contend cyc=%0d got=%h want=%h", cyc, got, want);
      else passes++;
      if (got.gnt0 || got.gnt1) begin
        checks++;
        if (got.gnt1 !== nseen[0] || got.gnt0 === got.gnt1 || (nseen > 0 && cyc - prev != 2))
          $display("FAIL contend_grant n=%0d gnt0=%b gnt1=%b gap=%0d want id=%0d gap=2",
                   nseen, got.gnt0, got.gnt1, cyc - prev, nseen % 2);
        else passes++;
        prev = cyc;
        nseen++;
      end
    end
    checks++;
    if (nseen != 8) $display("FAIL contend_count grants=%0d want 8", nseen);
    else passes++;
  endtask

  task automatic test_write_before_read();
    int b0 = comp[0];
    int b1 = comp[1];
    logic [15:0] rd1_keep;
    q1.push_back(mk(1'b1, 6'd63, 16'h1234));
    for (int i = 0; i < 20 && comp[1] < b1 + 1; i++) begin
      tick();
      checks++;
      if (got !== want) $display("FAIL wbr_write cyc=%0d got=%h want=%h", cyc, got, want);
      else passes++;
    end
    rd1_keep = want.rd1;
    q0.push_back(mk(1'b0, 6'd63, 16'($urandom)));
    for (int i = 0; i < 20 && comp[0] < b0 + 1; i++) begin
      tick();
      checks++;
      if (got !== want) $display("FAIL wbr_read cyc=%0d got=%h want=%h", cyc, got, want);
      else passes++;
    end
    checks++;
    if (got.rd0 !== 16'h1234 || got.rd1 !== rd1_keep)
      $display("FAIL wbr_data rdata0=%h rdata1=%h want 1234 and %h", got.rd0, got.rd1, rd1_keep);
    else passes++;
  endtask

  task automatic test_reset_mid_write();
    int b0 = comp[0];
    bit seen = 1'b0;
    q0.push_back(mk(1'b1, 6'd2, 16'h5A5A));
    for (int i = 0; i < 20 && comp[0] < b0 + 1; i++) begin
      tick();
      checks++;
      if (got !== want) $display("FAIL rmw_pre cyc=%0d got=%h want=%h", cyc, got, want);
      else passes++;
    end
    q0.push_back(mk(1'b1, 6'd2, 16'hAAAA));
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = got.gnt0;
      checks++;
      if (got !== want) $display("FAIL rmw_access cyc=%0d got=%h want=%h", cyc, got, want);
      else passes++;
    end
    checks++;
    if (!seen || got.load !== 1'b1) $display("FAIL rmw_no_access gnt0=%b load=%b want 1 1", seen, got.load);
    else passes++;
    #2 rst_i = 1'b0;
    #1 got = sample();
    reset_model();
    checks++;
    if (got.load !== 1'b0 || got !== want) $display("FAIL rmw_async got=%h want=%h", got, want);
    else passes++;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (got !== want) $display("FAIL rmw_hold cyc=%0d got=%h want=%h", cyc, got, want);
      else passes++;
    end
    rst_i = 1'b1;
    b0 = comp[0];
    q0.push_back(mk(1'b0, 6'd2, 16'($urandom)));
    for (int i = 0; i < 20 && comp[0] < b0 + 1; i++) begin
      tick();
      checks++;
      if (got !== want) $display("FAIL rmw_read cyc=%0d got=%h want=%h", cyc, got, want);
      else passes++;
    end
    checks++;
    if (got.rd0 !== 16'h5A5A) $display("FAIL rmw_prior rdata0=%h want 5a5a", got.rd0);
    else passes++;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (got !== want || got.gnt0 || got.gnt1 || got.rv0 || got.rv1 || got.load)
        $display("FAIL idle cyc=%0d got=%h want=%h", cyc, got, want);
      else passes++;
    end
  endtask

  task automatic test_random();
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      checks++;
      if (got !== want) $display("FAIL random cyc=%0d got=%h want=%h", cyc, got, want);
      else passes++;
    end
    rand_mode = 1'b0;
  endtask

  initial begin
    checks    = 0;
    passes    = 0;
    cyc       = 0;
    comp[0]   = 0;
    comp[1]   = 0;
    rand_mode = 1'b0;
    mem_init  = 1'b1;
    rst_i     = 1'b0;
    bus.req0_i = 1'b0; bus.we0_i = 1'b0; bus.addr0_i = 6'd0; bus.wdata0_i = 16'd0;
    bus.req1_i = 1'b0; bus.we1_i = 1'b0; bus.addr1_i = 6'd0; bus.wdata1_i = 16'd0;
    for (int i = 0; i < 64; i++) begin
      init_val[i]  = 16'($urandom);
      model_mem[i] = init_val[i];
    end

    test_reset();
    test_write_read();
    test_tie();
    test_contention();
    test_write_before_read();
    test_reset_mid_write();
    test_idle();
    test_random();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram64_arbiter.md
RAM64_ARBITER -- requirements
Module: ram64_arbiter

Interface
REQ-001 The block SHALL have the port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have the ports req0_i / req1_i, input, 1 bit each: requester 0/1 access request.
REQ-004 The block SHALL have the ports we0_i / we1_i, input, 1 bit each: 1 = write, 0 = read.
REQ-005 The block SHALL have the ports addr0_i / addr1_i, input, 6 bits each: word address 0..63.
REQ-006 The block SHALL have the ports wdata0_i / wdata1_i, input, 16 bits each: write data.
REQ-007 The block SHALL have the ports gnt0_o / gnt1_i... gnt0_o / gnt1_o, output, 1 bit each: grant pulse.
REQ-008 The block SHALL have the ports rvalid0_o / rvalid1_o, output, 1 bit each: completion pulse, for reads and writes.
REQ-009 The block SHALL have the ports rdata0_o / rdata1_o, output, 16 bits each: read data, valid while rvalidX_o = 1.
REQ-010 The block SHALL have the port ram_address_o, output, 6 bits: RAM address.
REQ-011 The block SHALL have the port ram_in_o, output, 16 bits: RAM write data.
REQ-012 The block SHALL have the port ram_load_o, output, 1 bit: RAM write enable.
REQ-013 The block SHALL have the port ram_out_i, input, 16 bits: RAM read data, combinational from ram_address_o.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-015 Arbitration SHALL occur only at a rising edge where the state is IDLE or RESP and at least one reqX_i = 1.
REQ-016 On a successful arbitration, the winner's we, addr and wdata SHALL be latched, the winner id SHALL be recorded, and the state SHALL go to ACCESS.
REQ-017 With a single active request, that requester SHALL win.
REQ-018 With both requests active, the requester not granted last SHALL win (round-robin); last_grant SHALL reset to 1, so requester 0 wins the first tie.
REQ-019 In IDLE with no request, the FSM SHALL stay in IDLE.
REQ-020 In RESP with no request, the FSM SHALL go to IDLE.
REQ-021 In ACCESS, gntX_o of the winner SHALL be 1 for exactly that one cycle; at most one gnt SHALL be high at any time.
REQ-022 In ACCESS, ram_address_o SHALL equal the latched address.
REQ-023 In ACCESS, ram_in_o SHALL equal the latched wdata.
REQ-024 In ACCESS, ram_load_o SHALL equal the latched we, giving exactly one write per write transaction.
REQ-025 Outside ACCESS, ram_load_o SHALL be 0; ram_address_o and ram_in_o SHALL hold their last values.
REQ-026 At the edge ending ACCESS, a read SHALL capture ram_out_i into the winner's rdataX_o; the state SHALL then go to RESP unconditionally.
REQ-027 A write SHALL leave rdataX_o unchanged.
REQ-028 In RESP, rvalidX_o of the winner SHALL be 1 for exactly one cycle.
REQ-029 rdataX_o SHALL hold its value until the next read for requester X.
REQ-030 Latency SHALL be: request sampled at edge E; gnt high in cycle E..E+1; rvalid high in cycle E+1..E+2.
REQ-031 Back-to-back throughput SHALL be one transaction per 2 cycles, via RESP->ACCESS.
REQ-032 Requester protocol: reqX_i and its payload SHALL be held stable until gntX_o is seen and dropped at the edge ending the gnt cycle; req still high at a RESP edge SHALL be treated as a new request.
REQ-033 The latched payload SHALL be used in ACCESS, so payload changes after the arbitration edge SHALL have no effect on the transaction.
REQ-034 Address SHALL be used modulo 64 with no range check; address 63 SHALL be legal, with no wrap side effects.

Reset
REQ-035 rst_i = 0 SHALL immediately, and independent of clk_i, force: state IDLE, last_grant = 1, all gnt/rvalid = 0, all rdata = 0, ram_address_o = 0, ram_in_o = 0, ram_load_o = 0.
REQ-036 Reset asserted during ACCESS SHALL abort the transaction: ram_load_o drops asynchronously, no rvalid is issued, and the transaction is not retried.
REQ-037 After rst_i returns to 1, arbitration SHALL resume at the first rising edge with a request.

Verification
REQ-038 Bench SHALL cover a single write then read: req0 write addr 3 data 16'hEFFF -> gnt0 in the next cycle, ram_load_o = 1 for one cycle at addr 3, rvalid0 a cycle later; then req0 read addr 3 -> rdata0_o = 16'hEFFF with rvalid0.
REQ-039 Bench SHALL cover a tie after reset: req0 and req1 both read, addr 2 and addr 63 -> gnt0 first, then gnt1 back-to-back via RESP->ACCESS; each rvalid pulse carries its own address contents.
REQ-040 Bench SHALL cover sustained contention: both requesters re-request continuously for 8 transactions -> grants alternate 0,1,0,1,...; no cycle with two gnts; 2-cycle spacing.
REQ-041 Bench SHALL cover write-before-read ordering: req1 write addr 63 data 16'h1234, then req0 read addr 63 -> rdata0_o = 16'h1234; rdata1_o unchanged.
REQ-042 Bench SHALL cover reset mid-write: rst_i = 0 during the ACCESS of a write to addr 2 data 16'hAAAA -> ram_load_o = 0 immediately, no rvalid; after reset, a read of addr 2 returns its prior value.
REQ-043 Bench SHALL cover an idle bus: no requests for 10 cycles -> state IDLE, ram_load_o = 0, all gnt/rvalid = 0 throughout.
